// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request initiator for a 16x8 synchronous RAM with a
// one-cycle registered read output. Requests arrive on a valid/ready handshake;
// writes complete one cycle after accept, reads two cycles after accept.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready only while idle and out of reset
//   req_we            1 = write, 0 = read
//   req_addr          target address
//   req_wdata         write data
//   rsp_valid         one-cycle completion pulse for reads and writes
//   rsp_rdata         last captured read byte, held until the next read completes
//   mem_enable        RAM enable
//   mem_we            RAM write enable
//   mem_address       RAM address, holds its last value when idle
//   mem_data          shared bidirectional RAM data bus
module mem_bus_master #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRdWait,
        StRdCap
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic                  rsp_q, rsp_d;
    logic                  accept;

    // Ready is gated by rst_n so it drops the instant reset asserts.
    assign req_ready = (state_q == StIdle) && rst_n;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        en_d    = en_q;
        we_d    = we_q;
        rsp_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    en_d    = 1'b1;
                    we_d    = req_we;
                    state_d = req_we ? StWr : StRdWait;
                end
            end
            StWr: begin
                en_d    = 1'b0;
                we_d    = 1'b0;
                rsp_d   = 1'b1;
                state_d = StIdle;
            end
            // RAM loads its output register at the end of this cycle.
            StRdWait: begin
                state_d = StRdCap;
            end
            // RAM is driving the bus during this cycle.
            StRdCap: begin
                rdata_d = mem_data;
                en_d    = 1'b0;
                rsp_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            we_q    <= we_d;
            rsp_q   <= rsp_d;
        end
    end

    assign mem_enable  = en_q;
    assign mem_we      = we_q;
    assign mem_address = addr_q;
    assign rsp_valid   = rsp_q;
    assign rsp_rdata   = rdata_q;

    // Both enable terms are registered, so the master only drives in write
    // cycles and never overlaps the RAM's read drive.
    assign mem_data = (en_q && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: self-checking bench for mem_bus_master. Contains a
// behavioural 16x8 RAM with a registered read output on the shared bus and a
// plain array model of memory contents used to predict read results.
module tb_mem_bus_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_enable;
    logic       mem_we;
    logic [3:0] mem_address;
    wire  [7:0] mem_data;

    int n_asserts = 0;
    int n_fails = 0;
    int cycles = 0;

    logic [7:0] model [16] = '{default: 8'h00};
    logic [7:0] last_rd = 8'h00;

    // RAM: writes on enable&we, loads output register on enable&!we, and drives
    // the bus in the following cycle while the read is still enabled.
    logic [7:0] ram [16] = '{default: 8'h00};
    logic [7:0] ram_out = 8'h00;
    logic       ram_rd_q = 1'b0;

    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (mem_enable && mem_we) ram[mem_address] <= mem_data;
        if (mem_enable && !mem_we) ram_out <= ram[mem_address];
        ram_rd_q <= mem_enable && !mem_we;
    end

    assign mem_data = (ram_rd_q && mem_enable && !mem_we) ? ram_out : 8'hzz;

    always #5 clk = ~clk;

    mem_bus_master #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_enable (mem_enable),
        .mem_we     (mem_we),
        .mem_address(mem_address),
        .mem_data   (mem_data)
    );

    // One complete transaction. Called at a negedge. hold keeps req_valid high
    // after accept; scramble changes the request fields while busy.
    task automatic do_op(input bit we, input logic [3:0] addr, input logic [7:0] data,
                         input bit hold, input bit scramble);
        int         n;
        int         e;
        logic [7:0] exp;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_asserts++;
        if (req_ready !== 1'b1) begin
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
            n_fails++;
            return;
        end
        exp       = we ? data : model[addr];
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = we ? data : ~exp;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        e = 0;
        while (rsp_valid !== 1'b1 && e < 6) begin
            n_asserts++;
            if (mem_enable !== 1'b1 || mem_we !== we || mem_address !== addr
                || req_ready !== 1'b0) begin
                $display("FAIL busy_outputs: en=%b we=%b addr=%h ready=%b required 1 %b %h 0",
                         mem_enable, mem_we, mem_address, req_ready, we, addr);
                n_fails++;
            end
            if (we || e == 1) begin
                n_asserts++;
                if (mem_data !== exp) begin
                    $display("FAIL bus_data: mem_data=%h required %h (we=%b cyc=%0d)",
                             mem_data, exp, we, e);
                    n_fails++;
                end
            end
            if (scramble) begin
                req_we    = 1'($urandom);
                req_addr  = 4'($urandom);
                req_wdata = 8'($urandom);
            end
            @(negedge clk);
            e++;
        end
        n_asserts++;
        if (e != (we ? 1 : 2)) begin
            $display("FAIL latency: cycles=%0d required %0d (we=%b)", e, we ? 1 : 2, we);
            n_fails++;
        end
        n_asserts++;
        if (mem_enable !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1
            || mem_address !== addr) begin
            $display("FAIL rsp_cycle: en=%b we=%b ready=%b addr=%h required 0 0 1 %h",
                     mem_enable, mem_we, req_ready, mem_address, addr);
            n_fails++;
        end
        if (we) begin
            model[addr] = data;
            n_asserts++;
            if (ram[addr] !== data) begin
                $display("FAIL ram_write: ram[%h]=%h required %h", addr, ram[addr], data);
                n_fails++;
            end
        end else begin
            last_rd = exp;
        end
        n_asserts++;
        if (rsp_rdata !== last_rd) begin
            $display("FAIL rsp_rdata: got %h required %h (we=%b addr=%h)",
                     rsp_rdata, last_rd, we, addr);
            n_fails++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'h5;
        req_wdata = 8'h77;
        repeat (3) @(negedge clk);
        n_asserts++;
        if (req_ready !== 1'b0 || mem_enable !== 1'b0 || mem_we !== 1'b0
            || mem_address !== 4'h0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
            $display("FAIL reset_state: ready=%b en=%b we=%b addr=%h rsp=%b rdata=%h required 0s",
                     req_ready, mem_enable, mem_we, mem_address, rsp_valid, rsp_rdata);
            n_fails++;
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #1;
        n_asserts++;
        if (req_ready !== 1'b1) begin
            $display("FAIL reset_release: req_ready=%b required 1", req_ready);
            n_fails++;
        end
        @(negedge clk);
        n_asserts++;
        if (mem_enable !== 1'b0 || rsp_valid !== 1'b0) begin
            $display("FAIL idle_after_reset: en=%b rsp=%b required 0 0", mem_enable, rsp_valid);
            n_fails++;
        end
    endtask

    task automatic test_write();
        do_op(1'b1, 4'h3, 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_read();
        do_op(1'b0, 4'h3, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int start;
        start = cycles;
        do_op(1'b1, 4'hF, 8'h3C, 1'b1, 1'b0);
        do_op(1'b0, 4'hF, 8'h00, 1'b1, 1'b0);
        do_op(1'b1, 4'h0, 8'hFF, 1'b1, 1'b0);
        do_op(1'b0, 4'h0, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;
        // write = 2 edges, read = 3 edges, counted from first accept edge.
        n_asserts++;
        if (cycles - start != 10) begin
            $display("FAIL b2b_throughput: edges=%0d required 10", cycles - start);
            n_fails++;
        end
    endtask

    task automatic test_scramble();
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 4'($urandom), 8'h00, 1'b1, 1'b1);
        end
        req_valid = 1'b0;
        do_op(1'b1, 4'h7, 8'h5A, 1'b0, 1'b1);
        do_op(1'b0, 4'h7, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            do_op(1'b0, 4'(a), 8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_read();
        do_op(1'b1, 4'h3, 8'hA5, 1'b0, 1'b0);
        do_op(1'b0, 4'h3, 8'h00, 1'b0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h3;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_asserts++;
        if (mem_enable !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0
            || rsp_rdata !== 8'h00 || req_ready !== 1'b0 || mem_address !== 4'h0) begin
            $display("FAIL async_reset: en=%b we=%b rsp=%b rdata=%h ready=%b addr=%h required 0s",
                     mem_enable, mem_we, rsp_valid, rsp_rdata, req_ready, mem_address);
            n_fails++;
        end
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_asserts++;
            if (rsp_valid !== 1'b0 || mem_enable !== 1'b0) begin
                $display("FAIL abandoned_op: rsp=%b en=%b required 0 0", rsp_valid, mem_enable);
                n_fails++;
            end
        end
        do_op(1'b0, 4'h3, 8'h00, 1'b0, 1'b0);
        n_asserts++;
        if (rsp_rdata !== 8'hA5) begin
            $display("FAIL read_after_reset: rdata=%h required a5", rsp_rdata);
            n_fails++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded required finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_scramble();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
